branch_pred_unit: RTL and testbench

BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

---
 rtl/branch_pred_unit_if.sv | 23 ++
 rtl/branch_pred_unit.sv | 55 +++++
 tb/tb_branch_pred_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/branch_pred_unit_if.sv
// branch_pred_unit_if: lookup, resolve and statistics signals of the branch predictor
interface branch_pred_unit_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
    logic [31:0] lk_pc;
    logic pred_taken;
    logic res_valid;
    logic [2:0] res_op;
    logic [31:0] res_pc;
    logic [WIDTH-1:0] res_rd1;
    logic [WIDTH-1:0] res_rd2;
    logic res_pred;
    logic res_taken;
    logic mispredict;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;
    modport master (
        output lk_pc, res_valid, res_op, res_pc, res_rd1, res_rd2, res_pred,
        input pred_taken, res_taken, mispredict, br_cnt, mis_cnt
    );
    modport slave (
        input lk_pc, res_valid, res_op, res_pc, res_rd1, res_rd2, res_pred,
        output pred_taken, res_taken, mispredict, br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_pred_unit.sv
// branch_pred_unit: 2-bit saturating-counter predictor with branch resolve and statistics
module branch_pred_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    branch_pred_unit_if.slave bp
);
    localparam int IDX_W = $clog2(DEPTH);
    logic [1:0] tbl [DEPTH];
    logic [IDX_W-1:0] lk_idx, res_idx;
    logic [1:0] ent;
    logic [2:0] op;
    logic sgn, zero, taken, valid, mis, mis_q;
    logic [CNT_W-1:0] br_q, mc_q;
    logic unused;
    assign lk_idx = bp.lk_pc[IDX_W+1:2];
    assign res_idx = bp.res_pc[IDX_W+1:2];
    assign unused = ^{bp.lk_pc[31:IDX_W+2], bp.lk_pc[1:0], bp.res_pc[31:IDX_W+2], bp.res_pc[1:0]};
    assign ent = tbl[res_idx];
    assign op = bp.res_op;
    // sign and zero tests of rd1 stand in for signed compares against 0
    assign sgn = bp.res_rd1[WIDTH-1];
    assign zero = ~|bp.res_rd1;
    always_comb begin
        taken = op == 3'd1 ? bp.res_rd1 == bp.res_rd2 :
                op == 3'd2 ? bp.res_rd1 != bp.res_rd2 :
                op == 3'd3 ? ~sgn :
                op == 3'd4 ? ~sgn & ~zero :
                op == 3'd5 ? sgn | zero :
                op == 3'd6 ? sgn : 1'b0;
        valid = bp.res_valid && op != 3'd0 && op != 3'd7;
        mis = valid && taken != bp.res_pred;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= 2'b01;
            mis_q <= 1'b0;
            br_q <= '0;
            mc_q <= '0;
        end else begin
            if (valid) tbl[res_idx] <= taken ? (&ent ? ent : ent + 2'd1) : (~|ent ? ent : ent - 2'd1);
            mis_q <= mis;
            if (valid && ~&br_q) br_q <= br_q + CNT_W'(1);
            if (mis && ~&mc_q) mc_q <= mc_q + CNT_W'(1);
        end
    end
    assign bp.pred_taken = tbl[lk_idx][1];
    assign bp.res_taken = taken;
    assign bp.mispredict = mis_q;
    assign bp.br_cnt = br_q;
    assign bp.mis_cnt = mc_q;
endmodule

// File: tb/tb_branch_pred_unit.sv
// tb_branch_pred_unit: directed checks of prediction, resolve, saturation and reset behaviour
module tb_branch_pred_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    branch_pred_unit_if #(.WIDTH(32), .CNT_W(16)) b16 ();
    branch_pred_unit_if #(.WIDTH(32), .CNT_W(2)) b2 ();
    branch_pred_unit #(.WIDTH(32), .DEPTH(16), .CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bp(b16.slave));
    branch_pred_unit #(.WIDTH(32), .DEPTH(16), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bp(b2.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic [31:0] lk, input logic v, input logic [2:0] op,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b, input logic p);
        b16.lk_pc = lk; b16.res_valid = v; b16.res_op = op; b16.res_pc = pc;
        b16.res_rd1 = a; b16.res_rd2 = b; b16.res_pred = p;
        b2.lk_pc = lk; b2.res_valid = v; b2.res_op = op; b2.res_pc = pc;
        b2.res_rd1 = a; b2.res_rd2 = b; b2.res_pred = p;
        #1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic stats(input string tag, input logic m, input int br, input int mc, input int br2, input int mc2);
        check({tag, "_mis"}, b16.mispredict, m);
        check({tag, "_br"}, b16.br_cnt, br);
        check({tag, "_mc"}, b16.mis_cnt, mc);
        check({tag, "_br2"}, b2.br_cnt, br2);
        check({tag, "_mc2"}, b2.mis_cnt, mc2);
    endtask
    initial begin
        // resolves presented during reset must be ignored
        drive(32'h3004, 1'b1, 3'd1, 32'h3004, 32'd5, 32'd5, 1'b0);
        tick(); tick();
        drive(32'h3000, 1'b0, 3'd0, 32'h3000, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        check("rst_pred", b16.pred_taken, 1'b0);
        stats("rst", 1'b0, 0, 0, 0, 0);
        drive(32'h3004, 1'b1, 3'd1, 32'h3004, 32'd5, 32'd5, 1'b0);
        check("beq_taken", b16.res_taken, 1'b1);
        check("beq_pred0", b16.pred_taken, 1'b0);
        tick();
        check("beq_pred1", b16.pred_taken, 1'b1);
        stats("beq1", 1'b1, 1, 1, 1, 1);
        tick();
        stats("beq2", 1'b1, 2, 2, 2, 2);
        tick();
        check("beq_pred3", b16.pred_taken, 1'b1);
        stats("beq3", 1'b1, 3, 3, 3, 3);
        drive(32'h3004, 1'b0, 3'd1, 32'h3004, 32'd5, 32'd5, 1'b0);
        tick();
        check("sat11_pred", b16.pred_taken, 1'b1);
        check("pulse_end", b16.mispredict, 1'b0);
        // comparator modes with no resolve in flight
        drive(32'h3004, 1'b0, 3'd2, 32'h0, 32'd5, 32'd6, 1'b0);
        check("bne_ne", b16.res_taken, 1'b1);
        drive(32'h3004, 1'b0, 3'd2, 32'h0, 32'd6, 32'd6, 1'b0);
        check("bne_eq", b16.res_taken, 1'b0);
        drive(32'h3004, 1'b0, 3'd1, 32'h0, 32'd6, 32'd7, 1'b0);
        check("beq_ne", b16.res_taken, 1'b0);
        drive(32'h3004, 1'b0, 3'd3, 32'h0, 32'd0, 32'd0, 1'b0);
        check("bgez_0", b16.res_taken, 1'b1);
        drive(32'h3004, 1'b0, 3'd3, 32'h0, 32'h8000_0000, 32'd0, 1'b0);
        check("bgez_neg", b16.res_taken, 1'b0);
        drive(32'h3004, 1'b0, 3'd4, 32'h0, 32'h7FFF_FFFF, 32'd0, 1'b0);
        check("bgtz_pos", b16.res_taken, 1'b1);
        drive(32'h3004, 1'b0, 3'd5, 32'h0, 32'd0, 32'd0, 1'b0);
        check("blez_0", b16.res_taken, 1'b1);
        drive(32'h3004, 1'b0, 3'd5, 32'h0, 32'd1, 32'd0, 1'b0);
        check("blez_pos", b16.res_taken, 1'b0);
        drive(32'h3004, 1'b0, 3'd6, 32'h0, 32'd0, 32'd0, 1'b0);
        check("bltz_0", b16.res_taken, 1'b0);
        drive(32'h3004, 1'b0, 3'd0, 32'h0, 32'd3, 32'd3, 1'b0);
        check("op0", b16.res_taken, 1'b0);
        drive(32'h3008, 1'b1, 3'd6, 32'h3008, 32'hFFFF_FFFF, 32'd0, 1'b1);
        check("bltz_taken", b16.res_taken, 1'b1);
        tick();
        check("bltz_pred", b16.pred_taken, 1'b1);
        stats("bltz", 1'b0, 4, 3, 3, 3);
        drive(32'h3008, 1'b1, 3'd4, 32'h3008, 32'd0, 32'd0, 1'b0);
        check("bgtz_0", b16.res_taken, 1'b0);
        tick();
        check("bgtz_pred", b16.pred_taken, 1'b0);
        stats("bgtz", 1'b0, 5, 3, 3, 3);
        // reserved and none opcodes must not count as resolves
        drive(32'h3008, 1'b1, 3'd7, 32'h3008, 32'd1, 32'd1, 1'b1);
        check("op7_taken", b16.res_taken, 1'b0);
        tick();
        stats("op7", 1'b0, 5, 3, 3, 3);
        drive(32'h3008, 1'b1, 3'd0, 32'h3008, 32'd1, 32'd1, 1'b1);
        tick();
        stats("op0v", 1'b0, 5, 3, 3, 3);
        check("op_inv_pred", b16.pred_taken, 1'b0);
        drive(32'h3008, 1'b1, 3'd1, 32'h3008, 32'd9, 32'd9, 1'b0);
        tick();
        stats("pre_rst", 1'b1, 6, 4, 3, 3);
        drive(32'h3008, 1'b0, 3'd0, 32'h3008, 32'd0, 32'd0, 1'b0);
        reset = 1'b0;
        tick();
        stats("mid_rst", 1'b0, 0, 0, 0, 0);
        reset = 1'b1;
        check("rst_e2", b16.pred_taken, 1'b0);
        drive(32'h3004, 1'b0, 3'd0, 32'h3004, 32'd0, 32'd0, 1'b0);
        check("rst_e1", b16.pred_taken, 1'b0);
        // lookup and update on the same entry in one cycle
        drive(32'h3044, 1'b1, 3'd1, 32'h3004, 32'd2, 32'd2, 1'b0);
        check("rbw_same", b16.pred_taken, 1'b0);
        tick();
        drive(32'h3044, 1'b0, 3'd1, 32'h3004, 32'd2, 32'd2, 1'b0);
        check("rbw_next", b16.pred_taken, 1'b1);
        stats("rbw", 1'b1, 1, 1, 1, 1);
        drive(32'h300C, 1'b1, 3'd2, 32'h300C, 32'd4, 32'd4, 1'b0);
        tick();
        tick();
        check("sat00_pred", b16.pred_taken, 1'b0);
        stats("nt", 1'b0, 3, 1, 3, 1);
        drive(32'h300C, 1'b1, 3'd1, 32'h300C, 32'd4, 32'd4, 1'b1);
        tick();
        check("sat00_up", b16.pred_taken, 1'b0);
        tick();
        drive(32'h300C, 1'b0, 3'd0, 32'h300C, 32'd0, 32'd0, 1'b0);
        check("up_10", b16.pred_taken, 1'b1);
        stats("cnt_sat", 1'b0, 5, 1, 3, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
